// File: rtl/mem_write_buffer_ctrl.sv
// Memory-side controller: posts cache writes into a FIFO write buffer drained to RAM,
// sequences read misses with a fixed RAM latency and forwards read hits from the buffer.
module mem_write_buffer_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WB_DEPTH = 4,
  parameter int RAM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              wb_empty
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(WB_DEPTH);
  localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PW-1:0]     head_reg, tail_reg, fwd_idx;
  logic [CW-1:0]     count_reg;
  logic [LW-1:0]     lat_reg;
  logic              rd_busy_reg, rd_pending_reg, hit_resp_reg;
  logic [ADDR_W-1:0] rd_addr_reg, ram_addr_reg;
  logic [DATA_W-1:0] ram_data_reg, resp_data_reg;

  logic              wb_full, accept, wr_accept, rd_accept, miss_accept, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign wb_full     = (count_reg == FULL_CNT);
  assign wb_empty    = (count_reg == '0);
  assign req_ready   = rst_n && !rd_busy_reg && !wb_full;
  assign accept      = req_valid && req_ready;
  assign wr_accept   = accept && req_wr;
  assign rd_accept   = accept && !req_wr;
  assign miss_accept = rd_accept && !fwd_hit;
  assign pop         = (state_reg == WRITE);

  assign resp_valid = (state_reg == RESP) || hit_resp_reg;
  assign resp_data  = resp_data_reg;
  assign ram_en     = (state_reg == WRITE) || (state_reg == READ);
  assign ram_wr     = (state_reg == WRITE);
  assign ram_addr   = ram_addr_reg;
  assign ram_data   = ram_data_reg;

  // Scan oldest to youngest so the last match wins; the head stays visible while it drains.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_idx = head_reg + PW'(i);
      if ((CW'(i) < count_reg) && (wb_addr[fwd_idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[fwd_idx];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rd_pending_reg || miss_accept) state_next = READ;
        else if (!wb_empty)                state_next = WRITE;
      end
      WRITE:   state_next = IDLE;
      READ:    if (lat_reg == LAT_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wb_addr[tail_reg] <= req_addr;
      wb_data[tail_reg] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (wr_accept) tail_reg <= tail_reg + PW'(1);
      if (pop)       head_reg <= head_reg + PW'(1);
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      lat_reg        <= '0;
      rd_busy_reg    <= 1'b0;
      rd_pending_reg <= 1'b0;
      hit_resp_reg   <= 1'b0;
      rd_addr_reg    <= '0;
      resp_data_reg  <= '0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      hit_resp_reg <= rd_accept && fwd_hit;
      lat_reg      <= (state_reg == READ && state_next == READ) ? lat_reg + LW'(1) : '0;

      if (rd_accept)                                    rd_busy_reg <= 1'b1;
      else if (state_reg == RESP || hit_resp_reg)       rd_busy_reg <= 1'b0;

      // A miss accepted while IDLE goes straight to READ and never sits pending.
      if (state_next == READ)  rd_pending_reg <= 1'b0;
      else if (miss_accept)    rd_pending_reg <= 1'b1;

      if (miss_accept) rd_addr_reg <= req_addr;

      if (rd_accept && fwd_hit)                         resp_data_reg <= fwd_data;
      else if (state_reg == READ && state_next == RESP) resp_data_reg <= ram_q;

      if (state_reg == IDLE && state_next == WRITE) begin
        ram_addr_reg <= wb_addr[head_reg];
        ram_data_reg <= wb_data[head_reg];
      end else if (state_reg != READ && state_next == READ) begin
        ram_addr_reg <= miss_accept ? req_addr : rd_addr_reg;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer_ctrl.sv
// Randomized scoreboard bench: a cache-view memory model predicts read data and latency,
// a pending-write queue predicts RAM write order, buffer occupancy and req_ready.
module tb_mem_write_buffer_ctrl;

  localparam int WB_DEPTH = 4;
  localparam int RAM_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        ram_en, ram_wr;
  logic [31:0] ram_addr, ram_data;
  logic [31:0] ram_q = '0;
  logic        wb_empty;

  mem_write_buffer_ctrl #(
    .DATA_W(32), .ADDR_W(32), .WB_DEPTH(WB_DEPTH), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_q(ram_q), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; bit hit; } rd_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  rd_t         sb[$];
  wr_t         pend[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] ram_mem   [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cycles = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural RAM: registered read, so ram_q is valid from the second READ cycle on.
  always @(posedge clk) begin
    cyc++;
    if (ram_en && ram_wr)  ram_mem[ram_addr] = ram_data;
    if (ram_en && !ram_wr) ram_q <= ram_rd(ram_addr);
  end

  // Monitor/scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      rd_t e;
      wr_t w;
      bit  hit;
      chk("req_ready", {31'b0, req_ready}, {31'b0, (sb.size() == 0) && (pend.size() < WB_DEPTH)});
      chk("wb_empty", {31'b0, wb_empty}, {31'b0, pend.size() == 0});

      if (ram_en && !ram_wr) begin
        if (sb.size() == 0 || sb[0].hit) chk("spurious_ram_read", {31'b0, ram_en}, 32'd0);
        else begin
          chk("ram_read_addr", ram_addr, sb[0].addr);
          rd_cycles++;
        end
      end

      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          $display("resp addr=%h data=%h hit=%0d cycle=%0d", e.addr, resp_data, e.hit, cyc);
          chk("resp_data", resp_data, e.data);
          chk("resp_cycle", cyc, e.cyc);
          if (!e.hit) chk("ram_read_cycles", rd_cycles, RAM_LAT);
          rd_cycles = 0;
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
        void'(sb.pop_front());
        rd_cycles = 0;
      end

      if (req_valid && req_ready) begin
        if (req_wr) begin
          pend.push_back('{addr: req_addr, data: req_data});
          model_mem[req_addr] = req_data;
          $display("write addr=%h data=%h cycle=%0d", req_addr, req_data, cyc);
        end else begin
          hit = 1'b0;
          foreach (pend[i]) if (pend[i].addr == req_addr) hit = 1'b1;
          e.addr = req_addr;
          e.data = model_rd(req_addr);
          e.hit  = hit;
          e.cyc  = hit ? cyc + 1 : cyc + RAM_LAT + 1 + ((ram_en && ram_wr) ? 1 : 0);
          sb.push_back(e);
          $display("read  addr=%h hit=%0d cycle=%0d", req_addr, hit, cyc);
        end
      end

      if (ram_en && ram_wr) begin
        if (pend.size() == 0) chk("spurious_ram_write", {31'b0, ram_wr}, 32'd0);
        else begin
          w = pend.pop_front();
          chk("ram_write_addr", ram_addr, w.addr);
          chk("ram_write_data", ram_data, w.data);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    chk("rst_wb_empty", {31'b0, wb_empty}, 32'd1);
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_data  = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((!wb_empty || sb.size() != 0 || pend.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", {31'b0, wb_empty}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simple miss
    issue(1'b0, 32'h10, 32'h0);
    wait_drain();

    // Forwarding, youngest entry wins
    issue(1'b1, 32'h20, 32'h1111);
    issue(1'b1, 32'h20, 32'h2222);
    issue(1'b0, 32'h20, 32'h0);
    wait_drain();

    // Buffer fill: back-to-back writes outrun the 1-per-2-cycle drain
    for (int i = 0; i < 10; i++) issue(1'b1, 32'(i), 32'hF000 + 32'(i));
    wait_drain();

    // Read miss queued behind pending writes
    issue(1'b1, 32'h30, 32'hA30);
    issue(1'b1, 32'h31, 32'hA31);
    issue(1'b1, 32'h32, 32'hA32);
    issue(1'b0, 32'h40, 32'h0);
    issue(1'b1, 32'h41, 32'hA41);
    issue(1'b1, 32'h42, 32'hA42);
    issue(1'b0, 32'h43, 32'h0);
    wait_drain();

    // Pointer wrap with read-back of each write
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 32'h100 + 32'(i), 32'hB000 + 32'(i));
      issue(1'b0, 32'h100 + 32'(i), 32'h0);
    end
    wait_drain();

    // Reset during the first READ cycle drops the read
    issue(1'b0, 32'h50, 32'h0);
    rst_n = 1'b0;
    sb.delete();
    rd_cycles = 0;
    #1;
    check_reset_vals();
    idle(2);
    rst_n = 1'b1;
    idle(8);

    // Randomized traffic over a small address set to provoke hits
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'h10 : 32'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), a, $urandom);
      idle($urandom_range(0, 2));
    end
    wait_drain();
    idle(4);

    foreach (model_mem[k]) chk("ram_final", ram_rd(k), model_mem[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
